lc3_decode_stage: RTL and testbench

//  LC-3 pipeline decode stage: the producing end of the decode_out bus.
//  - Captures the fetched instruction and NPC when enable_decode is high.
//  - Registers ir, npc_out, e_control, mem_control and w_control for the execute stage.
//  - One-cycle, enable-gated pipeline register with a combinational opcode decoder in front.

---
 rtl/lc3_decode_stage.sv | 128 ++++++++++++
 tb/tb_lc3_decode_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: combinational opcode decoder feeding an enable-gated
// pipeline register that drives ir/npc/control to the execute stage.
module lc3_decode_stage #(
  parameter logic [15:0] IR_RESET  = 16'h0000,
  parameter logic [15:0] NPC_RESET = 16'h3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] instr_dout,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  e_control,
  output logic        mem_control,
  output logic [1:0]  w_control,
  output logic        decode_valid
);

  // Capture protocol: enable_decode is a one-cycle load strobe. Every register
  // loads on a rising edge where it is high, and all of them hold otherwise
  // (no bubble). There is no back-pressure towards fetch.
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [1:0]  alu_d;
  logic [1:0]  pcsel1_d;
  logic        pcsel2_d;
  logic        op2sel_d;
  logic        mem_d;
  logic [1:0]  w_d;

  logic [15:0] ir_q;
  logic [15:0] npc_q;
  logic [5:0]  e_q;
  logic        mem_q;
  logic [1:0]  w_q;
  logic        valid_q;

  always_comb begin
    alu_d    = 2'b00;
    pcsel1_d = 2'b00;
    pcsel2_d = 1'b0;
    op2sel_d = 1'b0;
    mem_d    = 1'b0;
    w_d      = 2'b00;
    case (instr_dout[15:12])
      OP_ADD: op2sel_d = ~instr_dout[5];
      OP_AND: begin
        alu_d    = 2'b01;
        op2sel_d = ~instr_dout[5];
      end
      OP_NOT: begin
        alu_d    = 2'b10;
        op2sel_d = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcsel1_d = 2'b01;
        pcsel2_d = 1'b1;
      end
      OP_JMP: pcsel1_d = 2'b11;
      OP_LD: begin
        pcsel1_d = 2'b01;
        pcsel2_d = 1'b1;
        w_d      = 2'b01;
      end
      OP_LDI: begin
        pcsel1_d = 2'b01;
        pcsel2_d = 1'b1;
        w_d      = 2'b01;
        mem_d    = 1'b1;
      end
      OP_LDR: begin
        pcsel1_d = 2'b10;
        w_d      = 2'b01;
      end
      OP_LEA: begin
        pcsel1_d = 2'b01;
        pcsel2_d = 1'b1;
        w_d      = 2'b10;
      end
      OP_STI: begin
        pcsel1_d = 2'b01;
        pcsel2_d = 1'b1;
        mem_d    = 1'b1;
      end
      OP_STR: pcsel1_d = 2'b10;
      // JSR, RTI, reserved and TRAP fall through as a NOP decode.
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q    <= IR_RESET;
      npc_q   <= NPC_RESET;
      e_q     <= 6'b000000;
      mem_q   <= 1'b0;
      w_q     <= 2'b00;
      valid_q <= 1'b0;
    end else if (enable_decode) begin
      ir_q    <= instr_dout;
      npc_q   <= npc_in;
      e_q     <= {alu_d, pcsel1_d, pcsel2_d, op2sel_d};
      mem_q   <= mem_d;
      w_q     <= w_d;
      valid_q <= 1'b1;
    end
  end

  assign ir           = ir_q;
  assign npc_out      = npc_q;
  assign e_control    = e_q;
  assign mem_control  = mem_q;
  assign w_control    = w_q;
  assign decode_valid = valid_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Bench for lc3_decode_stage: reference decode table, expected-state queue,
// directed scenarios followed by random enable/instruction traffic.
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  e_control;
  logic        mem_control;
  logic [1:0]  w_control;
  logic        decode_valid;

  // Packed view: {ir, npc_out, e_control, mem_control, w_control, decode_valid}
  localparam int W = 42;
  localparam logic [W-1:0] RESET_STATE = {16'h0000, 16'h3000, 6'b0, 1'b0, 2'b0, 1'b0};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_state;
  int           n_vec;
  int           n_err;

  lc3_decode_stage #(.IR_RESET(16'h0000), .NPC_RESET(16'h3000)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .ir            (ir),
    .npc_out       (npc_out),
    .e_control     (e_control),
    .mem_control   (mem_control),
    .w_control     (w_control),
    .decode_valid  (decode_valid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {e_control, mem_control, w_control} straight from the opcode table.
  function automatic logic [8:0] ref_ctrl(input logic [15:0] ins);
    logic op2;
    op2 = ~ins[5];
    case (ins[15:12])
      4'b0001: ref_ctrl = {5'b00000, op2, 1'b0, 2'b00};
      4'b0101: ref_ctrl = {5'b01000, op2, 1'b0, 2'b00};
      4'b1001: ref_ctrl = {6'b100001, 1'b0, 2'b00};
      4'b0000: ref_ctrl = {6'b000110, 1'b0, 2'b00};
      4'b1100: ref_ctrl = {6'b001100, 1'b0, 2'b00};
      4'b0010: ref_ctrl = {6'b000110, 1'b0, 2'b01};
      4'b1010: ref_ctrl = {6'b000110, 1'b1, 2'b01};
      4'b0110: ref_ctrl = {6'b001000, 1'b0, 2'b01};
      4'b1110: ref_ctrl = {6'b000110, 1'b0, 2'b10};
      4'b0011: ref_ctrl = {6'b000110, 1'b0, 2'b00};
      4'b1011: ref_ctrl = {6'b000110, 1'b1, 2'b00};
      4'b0111: ref_ctrl = {6'b001000, 1'b0, 2'b00};
      default: ref_ctrl = 9'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] observed();
    return {ir, npc_out, e_control, mem_control, w_control, decode_valid};
  endfunction

  // driver: apply one cycle of stimulus, push expectation, compare after the edge
  task automatic drive_cycle(input logic en, input logic [15:0] ins, input logic [15:0] npc,
                             input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs;
    enable_decode = en;
    instr_dout    = ins;
    npc_in        = npc;
    if (en) model_state = {ins, npc, ref_ctrl(ins), 1'b1};
    exp_q.push_back(model_state);
    @(posedge clock);
    #1;
    exp_v = exp_q.pop_front();
    obs   = observed();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got ir=%h npc=%h e=%b mem=%b w=%b v=%b, want ir=%h npc=%h e=%b mem=%b w=%b v=%b",
               name, obs[41:26], obs[25:10], obs[9:4], obs[3], obs[2:1], obs[0],
               exp_v[41:26], exp_v[25:10], exp_v[9:4], exp_v[3], exp_v[2:1], exp_v[0]);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] obs;
    reset = 1'b1;
    enable_decode = 1'b0;
    instr_dout = 16'h0000;
    npc_in = 16'h0000;
    @(posedge clock);
    #1;
    drive_cycle(1'b1, 16'h1283, 16'h3001, "pre_reset_capture");
    #3;
    reset = 1'b0;
    #1;
    model_state = RESET_STATE;
    obs = observed();
    n_vec++;
    if (obs !== RESET_STATE) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", obs, RESET_STATE);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_add_and_ldr();
    drive_cycle(1'b1, 16'h1283, 16'h3001, "add_reg");
    drive_cycle(1'b1, 16'h5262, 16'h3002, "and_imm");
    drive_cycle(1'b1, 16'h6283, 16'h3003, "ldr");
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 16'hA205, 16'h3004, "ldi");
    drive_cycle(1'b1, 16'hE205, 16'h3005, "lea");
    drive_cycle(1'b1, 16'h927F, 16'h3006, "not");
    drive_cycle(1'b1, 16'h0A05, 16'h3007, "br");
    drive_cycle(1'b1, 16'hC1C0, 16'h3008, "jmp");
    drive_cycle(1'b1, 16'h2205, 16'h3009, "ld");
    drive_cycle(1'b1, 16'h3205, 16'h300A, "st");
    drive_cycle(1'b1, 16'hB205, 16'h300B, "sti");
    drive_cycle(1'b1, 16'h7283, 16'h300C, "str");
    drive_cycle(1'b1, 16'h4805, 16'h300D, "jsr_nop");
  endtask

  task automatic test_hold();
    drive_cycle(1'b1, 16'h1283, 16'h3010, "hold_capture");
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'hFFFF, 16'hBEEF, "hold");
    drive_cycle(1'b0, 16'hxxxx, 16'hxxxx, "hold_x_input");
  endtask

  task automatic test_reset_pending();
    logic [W-1:0] obs;
    #3;
    reset = 1'b0;
    enable_decode = 1'b1;
    instr_dout = 16'h1283;
    npc_in = 16'h3020;
    model_state = RESET_STATE;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      obs = observed();
      n_vec++;
      if (obs !== RESET_STATE) begin
        n_err++;
        $display("FAIL reset_pending: got %h want %h", obs, RESET_STATE);
      end
    end
    reset = 1'b1;
    drive_cycle(1'b1, 16'hF025, 16'h3021, "trap_after_reset");
  endtask

  task automatic test_random();
    logic        en;
    logic [15:0] ins;
    for (int i = 0; i < 60; i++) begin
      en  = 1'($urandom_range(0, 1));
      ins = 16'($urandom_range(0, 65535));
      drive_cycle(en, ins, 16'($urandom_range(0, 65535)), "random");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_state = RESET_STATE;
    reset = 1'b0;
    enable_decode = 1'b0;
    instr_dout = 16'h0000;
    npc_in = 16'h0000;
    #12;
    test_reset();
    test_add_and_ldr();
    test_back_to_back();
    test_hold();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
